// File: rtl/demux_pkg.sv
// Shared constants, select type and round-robin helper for the 1-to-4 stream demux.
package demux_pkg;

    localparam int unsigned NUM_OUT = 4;
    localparam int unsigned SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Mod-4 increment; the natural 2-bit wrap gives 3 -> 0.
    function automatic sel_t next_rr(input sel_t p);
        return p + sel_t'(1);
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register: holds a single beat until its consumer takes it.
module demux_out_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Load wins over drain so a same-cycle load/drain keeps the slot full with the new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer with explicit or round-robin channel selection.
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             rr_en,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr
);

    sel_t               r_rr_ptr;
    sel_t               w_tgt;
    logic               w_in_ready;
    logic               w_accept;
    logic [NUM_OUT-1:0] w_load;
    logic [NUM_OUT-1:0] w_valid;
    logic [WIDTH-1:0]   w_data [NUM_OUT];

    // Target decode and ready mux; a stalled target never diverts to another channel.
    always_comb begin
        w_tgt      = rr_en ? r_rr_ptr : in_sel;
        w_in_ready = !w_valid[w_tgt] || out_ready[w_tgt];
        w_accept   = in_valid && w_in_ready && !rst;
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        assign w_load[k] = w_accept && (w_tgt == sel_t'(k));

        demux_out_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load[k]),
            .i_data (in_data),
            .i_ready(out_ready[k]),
            .o_valid(w_valid[k]),
            .o_data (w_data[k])
        );
    end

    // Round-robin pointer advances only on an accepted beat in round-robin mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept && rr_en) begin
            r_rr_ptr <= next_rr(r_rr_ptr);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_valid;
    assign out_data0 = w_data[0];
    assign out_data1 = w_data[1];
    assign out_data2 = w_data[2];
    assign out_data3 = w_data[3];
    assign rr_ptr    = r_rr_ptr;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_demux_1to4_stream;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        rr_en;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [1:0]  rr_ptr;

    logic [31:0] dut_data [4];
    assign dut_data[0] = out_data0;
    assign dut_data[1] = out_data1;
    assign dut_data[2] = out_data2;
    assign dut_data[3] = out_data3;

    demux_1to4_stream #(
        .WIDTH(32)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rr_en    (rr_en),
        .out_data0(out_data0),
        .out_data1(out_data1),
        .out_data2(out_data2),
        .out_data3(out_data3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .rr_ptr   (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Behavioural model: four one-beat mailboxes and a pointer.
    bit          m_init = 0;
    bit          m_full [4];
    logic [31:0] m_data [4];
    int          m_ptr;
    int unsigned m_beats_in  = 0;
    int unsigned m_beats_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int target();
        return rr_en ? m_ptr : int'(in_sel);
    endfunction

    function automatic bit model_ready();
        int t;
        t = target();
        return !m_full[t] || out_ready[t];
    endfunction

    // One clock: check ready before the edge, advance the model at the edge, check state after.
    task automatic cycle();
        bit rdy;
        int t;
        #1;
        if (m_init) chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
        rdy = model_ready();
        t   = target();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 0;
                m_data[k] = '0;
            end
            m_ptr  = 0;
            m_init = 1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (in_valid && rdy && k == t) begin
                    if (m_full[k] && out_ready[k]) m_beats_out++;
                    m_full[k] = 1;
                    m_data[k] = in_data;
                    m_beats_in++;
                end else if (m_full[k] && out_ready[k]) begin
                    m_full[k] = 0;
                    m_beats_out++;
                end
            end
            if (in_valid && rdy && rr_en) m_ptr = (m_ptr + 1) % 4;
        end
        @(negedge clk);
        if (m_init) begin
            logic [3:0] ev;
            for (int k = 0; k < 4; k++) ev[k] = m_full[k];
            chk("out_valid", {28'b0, out_valid}, {28'b0, ev});
            chk("rr_ptr", {30'b0, rr_ptr}, 32'(m_ptr));
            for (int k = 0; k < 4; k++) chk($sformatf("out_data%0d", k), dut_data[k], m_data[k]);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d,
                         input bit rr, input logic [3:0] ordy);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        rr_en     = rr;
        out_ready = ordy;
    endtask

    task automatic idle_drain();
        drive(0, 2'd0, 32'h0, 0, 4'hF);
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 2'd0, 32'h0, 0, 4'h0);
        cycle();
        cycle();
        chk("reset out_valid literal", {28'b0, out_valid}, 32'h0);
        chk("reset rr_ptr literal", {30'b0, rr_ptr}, 32'h0);
        rst = 1'b0;

        // Explicit routing to channel 2.
        drive(1, 2'd2, 32'hDEAD_BEEF, 0, 4'hF);
        #1 chk("explicit in_ready literal", {31'b0, in_ready}, 32'h1);
        cycle();
        chk("explicit out_valid literal", {28'b0, out_valid}, 32'h4);
        chk("explicit out_data2 literal", out_data2, 32'hDEAD_BEEF);
        idle_drain();

        // Backpressure on channel 1.
        drive(1, 2'd1, 32'hA5A5_0001, 0, 4'h0);
        cycle();
        chk("bp first beat literal", out_data1, 32'hA5A5_0001);
        drive(1, 2'd1, 32'hA5A5_0002, 0, 4'h0);
        #1 chk("bp stall in_ready literal", {31'b0, in_ready}, 32'h0);
        cycle();
        chk("bp held data literal", out_data1, 32'hA5A5_0001);
        drive(1, 2'd1, 32'hA5A5_0002, 0, 4'b0010);
        #1 chk("bp release in_ready literal", {31'b0, in_ready}, 32'h1);
        cycle();
        chk("bp replace data literal", out_data1, 32'hA5A5_0002);
        chk("bp valid held literal", {31'b0, out_valid[1]}, 32'h1);
        idle_drain();

        // Round-robin wrap across six beats.
        for (int i = 1; i <= 6; i++) begin
            drive(1, 2'd3, 32'(i), 1, 4'hF);
            cycle();
            chk("rr landing valid literal", {28'b0, out_valid}, 32'(1 << ((i - 1) % 4)));
            chk("rr landing data literal", dut_data[(i - 1) % 4], 32'(i));
        end
        chk("rr wrap ptr literal", {30'b0, rr_ptr}, 32'h2);
        idle_drain();

        // Round-robin stall: bring pointer to 1, then fill channel 1.
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'd0, 32'h100 + 32'(i), 1, 4'hF);
            cycle();
        end
        drive(1, 2'd1, 32'h0000_0C11, 0, 4'b1101);
        cycle();
        drive(1, 2'd2, 32'h0000_0C22, 1, 4'b1101);
        #1 chk("rr stall in_ready literal", {31'b0, in_ready}, 32'h0);
        cycle();
        chk("rr stall ptr literal", {30'b0, rr_ptr}, 32'h1);
        chk("rr no divert literal", {31'b0, out_valid[2]}, 32'h0);
        drive(1, 2'd2, 32'h0000_0C22, 1, 4'hF);
        cycle();
        chk("rr release ptr literal", {30'b0, rr_ptr}, 32'h2);
        chk("rr release data literal", out_data1, 32'h0000_0C22);
        idle_drain();

        // Drain on channel 3 concurrent with a load on channel 0.
        drive(1, 2'd3, 32'h3333_3333, 0, 4'h0);
        cycle();
        chk("drain-else pre literal", {28'b0, out_valid}, 32'h8);
        drive(1, 2'd0, 32'h0000_0000 + 32'h1234, 0, 4'b1000);
        cycle();
        chk("drain-else post literal", {28'b0, out_valid}, 32'h1);
        idle_drain();

        // Fill all four channels via round-robin, leaving pointer at 3.
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'd0, 32'hF000 + 32'(i), 1, 4'h0);
            cycle();
        end
        drive(1, 2'd0, 32'hF0F0, 1, 4'b0100);
        cycle();
        drive(0, 2'd0, 32'h0, 0, 4'h0);
        cycle();
        chk("pre-reset valid literal", {28'b0, out_valid}, 32'hF);
        chk("pre-reset ptr literal", {30'b0, rr_ptr}, 32'h3);
        rst = 1'b1;
        drive(1, 2'd0, 32'hBAD0_BAD0, 1, 4'h0);
        cycle();
        rst = 1'b0;
        chk("mid reset valid literal", {28'b0, out_valid}, 32'h0);
        chk("mid reset ptr literal", {30'b0, rr_ptr}, 32'h0);
        for (int k = 0; k < 4; k++) chk("mid reset data literal", dut_data[k], 32'h0);
        drive(1, 2'd2, 32'h5151_5151, 1, 4'hF);
        cycle();
        chk("post reset landing literal", {28'b0, out_valid}, 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(bit'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
                  bit'($urandom_range(0, 1)), 4'($urandom));
            cycle();
        end
        rst = 1'b0;

        if (m_beats_in == 0) chk("random traffic accepted beats", 32'(m_beats_in), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
